// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_pkg
//  Purpose : Shared encodings for the memory responder: FSM states, bus
//            direction codes and the wait-state counter width.
//  Rev     : 1.0  initial release
// ============================================================================
package mem_pkg;

  // Two-state responder FSM
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // MEM_RW encodings as driven by the CPU
  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  // Wait-state counter width; supports WAIT_CYCLES up to 15
  localparam int WAIT_W = 4;

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
//  Module  : mem_array
//  Purpose : Single-port synchronous RAM, 2**ADDR_W x DATA_W, with a
//            registered read port. Storage is never cleared; only the read
//            register is reset so the bus output starts at zero.
//  Rev     : 1.0  initial release
// ============================================================================
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_q;

  // Storage write port; contents survive reset (program/data image)
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Read register only updates on a read, so it holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (en && !we) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module  : mem_responder
//  Purpose : Memory-side end of the CPU MEM_EN/MEM_RW + MFC handshake.
//            Latches a one-cycle request, holds MFC high for WAIT_CYCLES
//            cycles, then performs the access on the edge MFC drops.
//  Rev     : 1.0  initial release
// ============================================================================
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MEM_EN,
  input  logic              MEM_RW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              MFC,
  output logic              busy_err
);

  // Counter preload: cnt counts down to zero, the zero cycle is the last busy one
  localparam logic [WAIT_W-1:0] CNT_LOAD = WAIT_W'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rw_q, rw_d;
  logic                mfc_q, mfc_d;
  logic                busy_err_q, busy_err_d;
  logic                ram_en;
  logic                ram_we;

  // State, request latches and handshake registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rw_q       <= MEM_READ;
      mfc_q      <= 1'b0;
      busy_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      mfc_q      <= mfc_d;
      busy_err_q <= busy_err_d;
    end
  end

  // Next-state logic: accept in IDLE, count wait states, fire the RAM on the last one
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;
    mfc_d      = mfc_q;
    busy_err_d = busy_err_q;
    ram_en     = 1'b0;
    ram_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (MEM_EN) begin
          addr_d  = addr;
          wdata_d = data_in;
          rw_d    = MEM_RW;
          cnt_d   = CNT_LOAD;
          mfc_d   = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // A new strobe while busy is dropped but remembered
        if (MEM_EN) begin
          busy_err_d = 1'b1;
        end
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end else begin
          ram_en  = 1'b1;
          ram_we  = (rw_q == MEM_WRITE);
          mfc_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .clk   (clk),
    .rst_n (reset),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (data_out)
  );

  assign MFC      = mfc_q;
  assign busy_err = busy_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mem_responder
//  Purpose : Directed self-checking bench for mem_responder at WAIT_CYCLES
//            of 2, 1 and 15 (three instances sharing one request bus).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        MEM_EN;
  logic        MEM_RW;
  logic [7:0]  addr;
  logic [15:0] data_in;

  logic [15:0] dout2, dout1, dout15;
  logic        mfc2, mfc1, mfc15;
  logic        berr2, berr1, berr15;

  int n_checks = 0;
  int n_fail   = 0;

  // Last value each instance's data_out should show (shared: same traffic)
  logic [15:0] last_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(reset), .MEM_EN(MEM_EN), .MEM_RW(MEM_RW), .addr(addr),
    .data_in(data_in), .data_out(dout2), .MFC(mfc2), .busy_err(berr2)
  );
  mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .MEM_EN(MEM_EN), .MEM_RW(MEM_RW), .addr(addr),
    .data_in(data_in), .data_out(dout1), .MFC(mfc1), .busy_err(berr1)
  );
  mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(15)) u_dut15 (
    .clk(clk), .reset(reset), .MEM_EN(MEM_EN), .MEM_RW(MEM_RW), .addr(addr),
    .data_in(data_in), .data_out(dout15), .MFC(mfc15), .busy_err(berr15)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request on all instances; measures MFC-high width of each and checks read data
  task automatic req(input logic rw, input logic [7:0] a, input logic [15:0] d,
                     input logic [15:0] exp_rd);
    int w2, w1, w15;
    w2 = 0; w1 = 0; w15 = 0;
    @(negedge clk);
    MEM_EN = 1'b1; MEM_RW = rw; addr = a; data_in = d;
    @(negedge clk);
    MEM_EN = 1'b0;
    check("busy_data_held", 32'(dout2), 32'(last_rd));
    for (int i = 0; i < 20; i++) begin
      if (mfc2)  w2++;
      if (mfc1)  w1++;
      if (mfc15) w15++;
      @(negedge clk);
    end
    check("mfc_width_w2",  32'(w2),  32'd2);
    check("mfc_width_w1",  32'(w1),  32'd1);
    check("mfc_width_w15", 32'(w15), 32'd15);
    check("dout_w2",  32'(dout2),  32'(exp_rd));
    check("dout_w1",  32'(dout1),  32'(exp_rd));
    check("dout_w15", 32'(dout15), 32'(exp_rd));
    last_rd = exp_rd;
  endtask

  initial begin
    reset = 1'b0; MEM_EN = 1'b1; MEM_RW = 1'b1; addr = 8'h00; data_in = 16'h0000;
    last_rd = 16'h0000;

    // Reset held with a live strobe: nothing may start
    repeat (3) @(negedge clk);
    check("rst_mfc",  32'(mfc2),  32'd0);
    check("rst_dout", 32'(dout2), 32'd0);
    check("rst_berr", 32'(berr2), 32'd0);
    reset = 1'b1; MEM_EN = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle", 32'(mfc2), 32'd0);

    // Write leaves data_out alone; read returns the new word
    req(1'b0, 8'h10, 16'hBEEF, 16'h0000);
    req(1'b1, 8'h10, 16'h0000, 16'hBEEF);
    req(1'b0, 8'h05, 16'h1111, 16'hBEEF);
    req(1'b1, 8'h05, 16'h0000, 16'h1111);
    req(1'b0, 8'h06, 16'h2222, 16'h1111);

    // Re-request while busy: read 0x06, then a write strobe mid-access
    @(negedge clk);
    MEM_EN = 1'b1; MEM_RW = 1'b1; addr = 8'h06; data_in = 16'h0000;
    @(negedge clk);
    MEM_EN = 1'b1; MEM_RW = 1'b0; addr = 8'h06; data_in = 16'hDEAD;
    check("busy_mfc_e0", 32'(mfc2), 32'd1);
    @(negedge clk);
    MEM_EN = 1'b0;
    check("busy_mfc_e1", 32'(mfc2), 32'd1);
    @(negedge clk);
    check("busy_mfc_done", 32'(mfc2),  32'd0);
    check("busy_dout",     32'(dout2), 32'h2222);
    check("busy_err_set",  32'(berr2), 32'd1);
    repeat (20) @(negedge clk);
    last_rd = 16'h2222;
    req(1'b1, 8'h06, 16'h0000, 16'h2222);
    check("busy_err_sticky", 32'(berr2), 32'd1);

    // Reset in the middle of a write: the write must be dropped
    @(negedge clk);
    MEM_EN = 1'b1; MEM_RW = 1'b0; addr = 8'h05; data_in = 16'h00AA;
    @(negedge clk);
    MEM_EN = 1'b0;
    check("mw_mfc_busy", 32'(mfc2), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mw_mfc_async", 32'(mfc2),  32'd0);
    check("mw_berr_clr",  32'(berr2), 32'd0);
    check("mw_dout_clr",  32'(dout2), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    last_rd = 16'h0000;
    req(1'b1, 8'h05, 16'h0000, 16'h1111);

    // Back-to-back reads on the single-wait instance, one idle cycle apart
    @(negedge clk);
    MEM_EN = 1'b1; MEM_RW = 1'b1; addr = 8'h10;
    @(negedge clk);
    MEM_EN = 1'b0;
    check("b2b_busy1", 32'(mfc1), 32'd1);
    @(negedge clk);
    check("b2b_done1", 32'(mfc1),  32'd0);
    check("b2b_data1", 32'(dout1), 32'hBEEF);
    MEM_EN = 1'b1; MEM_RW = 1'b1; addr = 8'h05;
    @(negedge clk);
    MEM_EN = 1'b0;
    check("b2b_busy2", 32'(mfc1),  32'd1);
    check("b2b_hold",  32'(dout1), 32'hBEEF);
    @(negedge clk);
    check("b2b_done2", 32'(mfc1),  32'd0);
    check("b2b_data2", 32'(dout1), 32'h1111);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
